speed_tm_sched: RTL
===================

Name: speed_tm_sched

Overview:
Command scheduler in front of speed_tm (the OS-load fast-forward timing model). It queues run-to-address commands from the Ethernet debug path and launches them one at a time as a single-cycle 43-bit pulse. It tracks completion, timeout and abort, and selects speed_tm vs. the normal TM onto the CPU token path. One status response is returned per command.

Parameters:
QDEPTH, 4, command FIFO depth (power of 2, >=2)
MAX_CORES, 64, largest legal ncores value
DRAIN_CYCLES, 4, cycles tm_select stays high after done/abort so in-flight pipeline tokens retire

Ports:
gclk  input  iu_clk_type  clock bundle; all state on gclk.clk rising edge
rstn  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO not full
cmd_ncores  input  10  core count for command
cmd_addr  input  32  stop-at npc
cmd_timeout  input  32  max cycles; 0 = no timeout
abort  input  1  level; kill active command and flush queue
eth2speedtm  output  43  {ncores, valid, addr} to speed_tm; bit 32 is a 1-cycle launch pulse
speedtm_rst  output  1  1-cycle synchronous kill pulse to speed_tm rst
tm_running  input  1  speed_tm.running
tm_done  input  1  speed_tm.done
tm_select  output  1  1 = speed_tm drives tm2cpu
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_status  output  2  00 DONE, 01 TIMEOUT, 10 ABORT, 11 BADCFG
rsp_cycles  output  32  cycles from launch to termination, saturating
rsp_addr  output  32  addr of finished command
busy  output  1  FSM not IDLE
q_count  output  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Reset (rstn=0, async): FSM IDLE, FIFO empty, all outputs 0 except cmd_ready=1; counters 0.
- Push when cmd_valid&cmd_ready; cmd_ready = !full only (no full+pop bypass). q_count updates the cycle after push/pop.
- FSM IDLE: if !abort and FIFO non-empty: pop head. If ncores==0 or >MAX_CORES -> RESP with BADCFG, cycles=0, no launch. Else -> LAUNCH.
- LAUNCH (1 cycle): eth2speedtm={ncores,1,addr}; tm_select=1; cycle counter loaded with 1 -> WAIT_START. Outside LAUNCH eth2speedtm = 0.
- WAIT_START: waits for tm_running or tm_done (done may arrive with no running if npc already matches). tm_done -> DRAIN(DONE); tm_running -> RUN.
- RUN: counter increments each cycle, saturating at 32'hFFFF_FFFF. tm_done -> DRAIN(DONE).
- Timeout: in WAIT_START/RUN, when cmd_timeout!=0 and counter==cmd_timeout without done: speedtm_rst pulse -> DRAIN(TIMEOUT).
- Abort: in WAIT_START/RUN: speedtm_rst pulse, FIFO flushed same cycle -> DRAIN(ABORT). In IDLE: FIFO flushed, no response. In DRAIN/RESP: FIFO flushed; current response kept.
- Priority, same cycle: tm_done > abort > timeout.
- rsp_cycles = counter value in the cycle the terminating event is sampled.
- DRAIN: tm_select held 1 for DRAIN_CYCLES cycles, then 0 -> RESP.
- RESP: rsp_valid=1, payload stable until rsp_ready. Handshake cycle -> IDLE. Next launch no earlier than the following cycle.
- cmd pushes are accepted in every state; abort does not block a push in the same cycle. The pushed entry survives the flush: flush is applied before push.

Decomposition:
- libtm: speedtm_cmd_type struct {ncores[9:0], addr[31:0], timeout[31:0]}; speedtm_status_type enum (DONE/TIMEOUT/ABORT/BADCFG); speed_tm_sched_state_type enum.
- Sub-module speed_tm_cmd_fifo: parameterised QDEPTH sync FIFO with flush, async active-low reset; count output.

Test Plan:
- Push {4,0x4000_1000,0}. tm_running 2 cycles after launch, tm_done 50 cycles later -> exactly one launch pulse eth2speedtm=={10'd4,1,0x4000_1000}. After DRAIN_CYCLES tm_select falls. rsp: DONE, cycles=53, addr 0x4000_1000.
- Push {2,0x100,20}; tm_running, no done -> speedtm_rst pulse at counter 20; rsp TIMEOUT, cycles=20.
- Push 5 commands with QDEPTH=4 while busy -> 5th stalls (cmd_ready=0) until a pop. All complete in FIFO order.
- Abort during RUN with 3 queued -> speedtm_rst pulse, q_count=0 next cycle, single ABORT response, then idle.
- Push ncores=0 and ncores=65 -> two BADCFG responses, no eth2speedtm pulse, tm_select never 1.
- tm_done and abort same cycle -> DONE response, queue flushed. Also rstn low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/speed_tm_sched_pkg.sv
// Shared types for the speed_tm command scheduler.
//   iu_clk_type                : clock bundle (clk)
//   speedtm_cmd_type           : one queued run-to-address command
//   speedtm_status_type        : response status codes
//   speed_tm_sched_state_type  : scheduler FSM states
//   ncores_legal()             : range check applied to a command before launch
package speed_tm_sched_pkg;

  typedef struct packed {
    logic clk;
  } iu_clk_type;

  typedef struct packed {
    logic [9:0]  ncores;
    logic [31:0] addr;
    logic [31:0] timeout;
  } speedtm_cmd_type;

  typedef enum logic [1:0] {
    ST_DONE    = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ABORT   = 2'b10,
    ST_BADCFG  = 2'b11
  } speedtm_status_type;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_START,
    S_RUN,
    S_DRAIN,
    S_RESP
  } speed_tm_sched_state_type;

  function automatic logic ncores_legal(input logic [9:0] ncores,
                                        input int unsigned max_cores);
    return (ncores != '0) && (32'(ncores) <= max_cores);
  endfunction

endpackage

// File: rtl/speed_tm_cmd_fifo.sv
// Command FIFO for speed_tm_sched.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/din   : write one command (ignored when full)
//   pop/dout   : dout shows the head; pop advances it
//   flush      : empties the queue; a push in the same cycle is kept
//   full/empty/count : occupancy, registered
module speed_tm_cmd_fifo
  import speed_tm_sched_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  speedtm_cmd_type           din,
  input  logic                      pop,
  input  logic                      flush,
  output speedtm_cmd_type           dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int unsigned AW = $clog2(QDEPTH);

  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wr_idx;
  logic            do_push, do_pop;
  speedtm_cmd_type mem_q [QDEPTH];

  assign full  = (count_q == (AW+1)'(QDEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Flush resets the pointers first, so a simultaneous push lands in slot 0
  // and becomes the only entry.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_idx   = wr_ptr_q;
    if (flush) begin
      wr_idx   = '0;
      rd_ptr_d = '0;
      wr_ptr_d = do_push ? AW'(1) : '0;
      count_d  = do_push ? (AW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/speed_tm_sched.sv
// Command scheduler in front of speed_tm.
// Queues run-to-address commands, launches them one at a time as a single
// cycle pulse on eth2speedtm, tracks done/timeout/abort, steers the CPU token
// path (tm_select) and returns one status response per command.
//   gclk, rstn          : clock bundle, asynchronous active-low reset
//   cmd_*               : command push interface (cmd_ready = FIFO not full)
//   abort               : level; kills the active command and flushes the queue
//   eth2speedtm         : {ncores, launch, addr}, non-zero only in the launch cycle
//   speedtm_rst         : one-cycle kill pulse to speed_tm
//   tm_running, tm_done : speed_tm status
//   tm_select           : 1 while speed_tm owns tm2cpu (incl. drain window)
//   rsp_*               : response, held until rsp_ready
//   busy, q_count       : FSM not idle, queue occupancy
module speed_tm_sched
  import speed_tm_sched_pkg::*;
#(
  parameter int unsigned QDEPTH       = 4,
  parameter int unsigned MAX_CORES    = 64,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  iu_clk_type                gclk,
  input  logic                      rstn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [9:0]                cmd_ncores,
  input  logic [31:0]               cmd_addr,
  input  logic [31:0]               cmd_timeout,
  input  logic                      abort,
  output logic [42:0]               eth2speedtm,
  output logic                      speedtm_rst,
  input  logic                      tm_running,
  input  logic                      tm_done,
  output logic                      tm_select,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [1:0]                rsp_status,
  output logic [31:0]               rsp_cycles,
  output logic [31:0]               rsp_addr,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  logic clk;
  assign clk = gclk.clk;

  speed_tm_sched_state_type state_q, state_d;
  speedtm_cmd_type          cur_q, cur_d;
  speedtm_status_type       status_q, status_d;
  logic [31:0]              cnt_q, cnt_d;
  logic [31:0]              rsp_cycles_q, rsp_cycles_d;
  logic [DW-1:0]            drain_q, drain_d;
  logic                     speedtm_rst_q, speedtm_rst_d;

  speedtm_cmd_type fifo_din, fifo_head;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]     cnt_inc;
  logic            timeout_hit;

  assign fifo_din  = '{ncores: cmd_ncores, addr: cmd_addr, timeout: cmd_timeout};
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;

  speed_tm_cmd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rstn),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .flush (abort),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (q_count)
  );

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  assign timeout_hit = (cur_q.timeout != '0) && (cnt_q == cur_q.timeout);

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    status_d      = status_q;
    cnt_d         = cnt_q;
    rsp_cycles_d  = rsp_cycles_q;
    drain_d       = drain_q;
    speedtm_rst_d = 1'b0;
    fifo_pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!abort && !fifo_empty) begin
          fifo_pop = 1'b1;
          cur_d    = fifo_head;
          if (ncores_legal(fifo_head.ncores, MAX_CORES)) begin
            state_d = S_LAUNCH;
            cnt_d   = 32'd1;
          end else begin
            state_d      = S_RESP;
            status_d     = ST_BADCFG;
            rsp_cycles_d = '0;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = cnt_inc;
        state_d = S_WAIT_START;
      end
      S_WAIT_START, S_RUN: begin
        cnt_d = cnt_inc;
        // Terminating events in priority order: done, abort, timeout.
        if (tm_done || abort || timeout_hit) begin
          state_d      = S_DRAIN;
          drain_d      = DRAIN_LOAD;
          rsp_cycles_d = cnt_q;
          if (tm_done) begin
            status_d = ST_DONE;
          end else begin
            speedtm_rst_d = 1'b1;
            status_d      = abort ? ST_ABORT : ST_TIMEOUT;
          end
        end else if (state_q == S_WAIT_START && tm_running) begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_RESP;
        else               drain_d = drain_q - DW'(1);
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cur_q         <= '0;
      status_q      <= ST_DONE;
      cnt_q         <= '0;
      rsp_cycles_q  <= '0;
      drain_q       <= '0;
      speedtm_rst_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      status_q      <= status_d;
      cnt_q         <= cnt_d;
      rsp_cycles_q  <= rsp_cycles_d;
      drain_q       <= drain_d;
      speedtm_rst_q <= speedtm_rst_d;
    end
  end

  assign eth2speedtm = (state_q == S_LAUNCH) ? {cur_q.ncores, 1'b1, cur_q.addr} : '0;
  assign tm_select   = (state_q == S_LAUNCH) || (state_q == S_WAIT_START) ||
                       (state_q == S_RUN)    || (state_q == S_DRAIN);
  assign speedtm_rst = speedtm_rst_q;
  assign busy        = (state_q != S_IDLE);
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_status  = rsp_valid ? status_q : 2'b00;
  assign rsp_cycles  = rsp_valid ? rsp_cycles_q : '0;
  assign rsp_addr    = rsp_valid ? cur_q.addr : '0;

endmodule
